// File: rtl/hazard_flush_ctrl.sv
// Pipeline hazard/flush controller: RAW stalls, branch flushes and memory-wait freezes.
// Define HAZARD_FWD_EN when a forwarding unit is present (load-use stalls only).
module hazard_flush_ctrl #(
  parameter int unsigned FLUSH_DEPTH = 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       src1,
  input  logic [3:0]       src2,
  input  logic             src1Vld,
  input  logic             src2Vld,
  input  logic [3:0]       exeDest,
  input  logic             exeWbEn,
  input  logic             exeMemrEn,
  input  logic [3:0]       memDest,
  input  logic             memWbEn,
  input  logic             bTaken,
  input  logic             memBusy,
  output logic             freezePc,
  output logic             freezeIfId,
  output logic             freezeAll,
  output logic             flushIfId,
  output logic             flushIdEx,
  output logic [CNT_W-1:0] stallCnt,
  output logic [CNT_W-1:0] flushCnt
);

  typedef enum logic [1:0] {StRun, StBrFlush, StMemWait} state_e;

  state_e     stateQ, stateD;
  logic [2:0] cntQ, cntD;
  logic       stallInc, flushInc;
  logic       fPc, fIfId, fAll, flIfId, flIdEx;
  logic       hazard;

  logic exeM1, exeM2, memM1, memM2;
  assign exeM1 = src1Vld && (exeDest == src1);
  assign exeM2 = src2Vld && (exeDest == src2);
  assign memM1 = src1Vld && (memDest == src1);
  assign memM2 = src2Vld && (memDest == src2);

`ifdef HAZARD_FWD_EN
  logic unusedIn;
  assign unusedIn = ^{memM1, memM2, memWbEn};
  assign hazard   = exeMemrEn && exeWbEn && (exeM1 || exeM2);
`else
  logic unusedIn;
  assign unusedIn = exeMemrEn;
  // Without forwarding the consumer waits until the producer has left MEM.
  assign hazard   = (exeWbEn && (exeM1 || exeM2)) || (memWbEn && (memM1 || memM2));
`endif

  always_comb begin
    stateD   = stateQ;
    cntD     = cntQ;
    stallInc = 1'b0;
    flushInc = 1'b0;
    fPc      = 1'b0;
    fIfId    = 1'b0;
    fAll     = 1'b0;
    flIfId   = 1'b0;
    flIdEx   = 1'b0;
    unique case (stateQ)
      StBrFlush: begin
        if (memBusy) begin
          fAll  = 1'b1;
          fPc   = 1'b1;
          fIfId = 1'b1;
        end else begin
          flIfId   = 1'b1;
          flIdEx   = 1'b1;
          flushInc = 1'b1;
          cntD     = cntQ - 3'd1;
          if (cntQ == 3'd1) stateD = StRun;
        end
      end
      // MEMWAIT with memBusy low falls straight into the RUN evaluation.
      default: begin
        if (memBusy) begin
          fAll   = 1'b1;
          fPc    = 1'b1;
          fIfId  = 1'b1;
          stateD = StMemWait;
        end else if (bTaken) begin
          flIfId   = 1'b1;
          flIdEx   = 1'b1;
          flushInc = 1'b1;
          if (FLUSH_DEPTH > 1) begin
            stateD = StBrFlush;
            cntD   = 3'(FLUSH_DEPTH - 1);
          end else begin
            stateD = StRun;
          end
        end else if (hazard) begin
          fPc      = 1'b1;
          fIfId    = 1'b1;
          flIdEx   = 1'b1;
          stallInc = 1'b1;
          stateD   = StRun;
        end else begin
          stateD = StRun;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateQ   <= StRun;
      cntQ     <= 3'd0;
      stallCnt <= '0;
      flushCnt <= '0;
    end else begin
      stateQ <= stateD;
      cntQ   <= cntD;
      if (stallInc && (stallCnt != {CNT_W{1'b1}})) stallCnt <= stallCnt + 1'b1;
      if (flushInc && (flushCnt != {CNT_W{1'b1}})) flushCnt <= flushCnt + 1'b1;
    end
  end

  // Controls are forced low for the whole time reset is held.
  assign freezePc   = rst & fPc;
  assign freezeIfId = rst & fIfId;
  assign freezeAll  = rst & fAll;
  assign flushIfId  = rst & flIfId;
  assign flushIdEx  = rst & flIdEx;

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// Bench for hazard_flush_ctrl: hazard vector table plus branch/memory-wait/reset sequences.
module tb_hazard_flush_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] src1, src2, exeDest, memDest;
  logic       src1Vld, src2Vld, exeWbEn, exeMemrEn, memWbEn, bTaken, memBusy;

  logic        fPc1, fIfId1, fAll1, flIfId1, flIdEx1;
  logic [15:0] stallCnt1, flushCnt1;
  logic        fPc2, fIfId2, fAll2, flIfId2, flIdEx2;
  logic [3:0]  stallCnt2, flushCnt2;

  always #5 clk = ~clk;

  hazard_flush_ctrl #(.FLUSH_DEPTH(3), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .src1(src1), .src2(src2), .src1Vld(src1Vld), .src2Vld(src2Vld),
    .exeDest(exeDest), .exeWbEn(exeWbEn), .exeMemrEn(exeMemrEn), .memDest(memDest),
    .memWbEn(memWbEn), .bTaken(bTaken), .memBusy(memBusy), .freezePc(fPc1),
    .freezeIfId(fIfId1), .freezeAll(fAll1), .flushIfId(flIfId1), .flushIdEx(flIdEx1),
    .stallCnt(stallCnt1), .flushCnt(flushCnt1)
  );

  // Second instance: single-cycle flush and narrow counters for saturation.
  hazard_flush_ctrl #(.FLUSH_DEPTH(1), .CNT_W(4)) dut2 (
    .clk(clk), .rst(rst), .src1(src1), .src2(src2), .src1Vld(src1Vld), .src2Vld(src2Vld),
    .exeDest(exeDest), .exeWbEn(exeWbEn), .exeMemrEn(exeMemrEn), .memDest(memDest),
    .memWbEn(memWbEn), .bTaken(bTaken), .memBusy(memBusy), .freezePc(fPc2),
    .freezeIfId(fIfId2), .freezeAll(fAll2), .flushIfId(flIfId2), .flushIdEx(flIdEx2),
    .stallCnt(stallCnt2), .flushCnt(flushCnt2)
  );

`ifdef HAZARD_FWD_EN
  localparam bit Fwd = 1'b1;
`else
  localparam bit Fwd = 1'b0;
`endif

  // Control bundle order: {freezePc, freezeIfId, freezeAll, flushIfId, flushIdEx}
  localparam logic [4:0] Z = 5'b00000;
  localparam logic [4:0] S = 5'b11001;
  localparam logic [4:0] F = 5'b00011;
  localparam logic [4:0] W = 5'b11100;

  typedef struct {
    string      nm;
    logic [3:0] s1, s2;
    logic       v1, v2;
    logic [3:0] eD;
    logic       eWb, eMr;
    logic [3:0] mD;
    logic       mWb, bT, mB;
    logic [4:0] expNoFwd, expFwd;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int expStall = 0;
  int expFlush = 0;

  logic [4:0] expQ[$];
  string      nameQ[$];
  vec_t       tbl[$];

  function automatic logic [4:0] ctl1();
    return {fPc1, fIfId1, fAll1, flIfId1, flIdEx1};
  endfunction

  function automatic logic [4:0] ctl2();
    return {fPc2, fIfId2, fAll2, flIfId2, flIdEx2};
  endfunction

  function automatic vec_t mkv(input string nm, input logic [3:0] s1, input logic [3:0] s2,
                               input logic v1, input logic v2, input logic [3:0] eD,
                               input logic eWb, input logic eMr, input logic [3:0] mD,
                               input logic mWb, input logic bT, input logic mB,
                               input logic [4:0] eNo, input logic [4:0] eFw);
    vec_t v;
    v.nm = nm; v.s1 = s1; v.s2 = s2; v.v1 = v1; v.v2 = v2; v.eD = eD; v.eWb = eWb;
    v.eMr = eMr; v.mD = mD; v.mWb = mWb; v.bT = bT; v.mB = mB;
    v.expNoFwd = eNo; v.expFwd = eFw;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    src1 = v.s1; src2 = v.s2; src1Vld = v.v1; src2Vld = v.v2; exeDest = v.eD;
    exeWbEn = v.eWb; exeMemrEn = v.eMr; memDest = v.mD; memWbEn = v.mWb;
    bTaken = v.bT; memBusy = v.mB;
  endtask

  // One cycle: drive after the rising edge, push expectation, pop and compare mid-cycle.
  task automatic step(input vec_t v);
    logic [4:0] e;
    string      n;
    @(posedge clk);
    #1;
    drive(v);
    expQ.push_back(Fwd ? v.expFwd : v.expNoFwd);
    nameQ.push_back(v.nm);
    @(negedge clk);
    e = expQ.pop_front();
    n = nameQ.pop_front();
    check(n, 32'(ctl1()), 32'(e));
    if (e == S) expStall++;
    if (e == F) expFlush++;
  endtask

  task automatic idleCheck(input string nm);
    step(mkv({nm, "_idle"}, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, Z, Z));
    check({nm, "_stallCnt"}, 32'(stallCnt1), 32'(expStall));
    check({nm, "_flushCnt"}, 32'(flushCnt1), 32'(expFlush));
  endtask

  vec_t idle, brV, waitBrV, busyV, loadUse;

  initial begin
    idle    = mkv("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, Z, Z);
    brV     = mkv("branch", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, F, F);
    waitBrV = mkv("memwait_branch", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, W, W);
    busyV   = mkv("brflush_busy", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, W, W);
    loadUse = mkv("load_use_r4", 4, 0, 1, 0, 4, 1, 1, 0, 0, 0, 0, S, S);

    tbl.push_back(mkv("all_idle",         0,  0, 0, 0,  0, 0, 0, 0, 0, 0, 0, Z, Z));
    tbl.push_back(mkv("exe_raw_src2",     0,  2, 0, 1,  2, 1, 0, 0, 0, 0, 0, S, Z));
    tbl.push_back(mkv("exe_src2_novld",   0,  2, 0, 0,  2, 1, 0, 0, 0, 0, 0, Z, Z));
    tbl.push_back(mkv("mem_raw_src1",     7,  0, 1, 0,  0, 0, 0, 7, 1, 0, 0, S, Z));
    tbl.push_back(mkv("exe_wb_off",       5,  0, 1, 0,  5, 0, 0, 0, 0, 0, 0, Z, Z));
    tbl.push_back(mkv("src1_novld_load",  3,  0, 0, 0,  3, 1, 1, 0, 0, 0, 0, Z, Z));
    tbl.push_back(mkv("r0_raw",           0,  0, 1, 0,  0, 1, 0, 0, 0, 0, 0, S, Z));
    tbl.push_back(mkv("load_use_r15",     0, 15, 0, 1, 15, 1, 1, 0, 0, 0, 0, S, S));
    tbl.push_back(mkv("load_use_src1_r4", 4,  0, 1, 0,  4, 1, 1, 0, 0, 0, 0, S, S));
    tbl.push_back(mkv("load_no_wb",       4,  0, 1, 0,  4, 0, 1, 0, 0, 0, 0, Z, Z));
    tbl.push_back(mkv("mem_wb_off",       9,  0, 1, 0,  0, 0, 0, 9, 0, 0, 0, Z, Z));
    tbl.push_back(mkv("no_match",         1,  2, 1, 1,  3, 1, 1, 4, 1, 0, 0, Z, Z));
    tbl.push_back(mkv("t4_exe_stage",     0,  2, 0, 1,  2, 1, 0, 0, 0, 0, 0, S, Z));
    tbl.push_back(mkv("t4_mem_stage",     0,  2, 0, 1,  0, 0, 0, 2, 1, 0, 0, S, Z));
    tbl.push_back(mkv("t4_cleared",       0,  2, 0, 1,  0, 0, 0, 0, 0, 0, 0, Z, Z));

    // Power-on reset with active inputs: every control must stay low.
    rst = 1'b1;
    drive(waitBrV);
    #1 rst = 1'b0;
    #2;
    check("reset_ctl", 32'(ctl1()), 32'(Z));
    check("reset_stallCnt", 32'(stallCnt1), 0);
    check("reset_flushCnt", 32'(flushCnt1), 0);
    drive(idle);
    @(negedge clk);
    rst = 1'b1;

    foreach (tbl[i]) step(tbl[i]);
    idleCheck("table");

    // Three-cycle branch flush; a hazard in the squashed ID slot is ignored.
    step(brV);
    step(mkv("brflush_hazard_ignored", 4, 0, 1, 0, 4, 1, 1, 0, 0, 0, 0, F, F));
    check("depth1_stalls_instead", 32'(ctl2()), 32'(S));
    step(mkv("brflush_last", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, F, F));
    idleCheck("branch");

    // Five-cycle memory wait with a pending branch, flushed afterwards.
    for (int i = 0; i < 5; i++) step(waitBrV);
    step(brV);
    check("memwait_flushCnt_before", 32'(flushCnt1), 32'(expFlush - 1));
    step(mkv("memwait_flush2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, F, F));
    step(mkv("memwait_flush3", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, F, F));
    idleCheck("memwait");

    // memBusy inside BRFLUSH freezes and holds the remaining flush count.
    step(brV);
    step(busyV);
    step(busyV);
    step(mkv("brflush_resume1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, F, F));
    step(mkv("brflush_resume2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, F, F));
    idleCheck("brflush_busy");

    // Asynchronous reset in the middle of BRFLUSH.
    step(brV);
    @(posedge clk);
    #1 drive(brV);
    #2 rst = 1'b0;
    #1;
    check("midflush_reset_ctl", 32'(ctl1()), 32'(Z));
    check("midflush_reset_stallCnt", 32'(stallCnt1), 0);
    check("midflush_reset_flushCnt", 32'(flushCnt1), 0);
    @(posedge clk);
    #1;
    check("reset_held_ctl", 32'(ctl1()), 32'(Z));
    drive(idle);
    @(negedge clk);
    rst = 1'b1;
    expStall = 0;
    expFlush = 0;
    idleCheck("after_reset");

    // Saturation: narrow counter pins at 15, wide one keeps counting.
    for (int i = 0; i < 20; i++) step(loadUse);
    idleCheck("saturate");
    check("sat_stallCnt_cw4", 32'(stallCnt2), 32'((expStall > 15) ? 15 : expStall));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
